// File: rtl/mouse_region_sequencer_if.sv
// MouseCtl-facing limit/position load port of the region sequencer.
// One strobe at a time, value valid alongside it; busy and active_mode are status.
interface mouse_region_sequencer_if #(
    parameter int NUM_REGIONS = 4,
    parameter int VW          = 12
);
    localparam int AW = $clog2(NUM_REGIONS);

    logic          setmin_x;
    logic          setmax_x;
    logic          setmin_y;
    logic          setmax_y;
    logic          setx;
    logic          sety;
    logic [VW-1:0] value;
    logic          busy;
    logic [AW-1:0] active_mode;

    modport master (
        output setmin_x, setmax_x, setmin_y, setmax_y, setx, sety,
        output value, busy, active_mode
    );

    modport slave (
        input setmin_x, setmax_x, setmin_y, setmax_y, setx, sety,
        input value, busy, active_mode
    );
endinterface

// File: rtl/mouse_region_sequencer.sv
// Serially programs MouseCtl cursor limits (and optional re-centre) from a region table on button edges.
// Latency: pin edge to first strobe 4 cycles; no backpressure, requests during a sequence queue as latest-wins.
module mouse_region_sequencer #(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            VW          = 12,
    parameter logic [NUM_REGIONS*VW-1:0]     MIN_X_TAB   = {NUM_REGIONS{VW'(0)}},
    parameter logic [NUM_REGIONS*VW-1:0]     MAX_X_TAB   = {NUM_REGIONS{VW'(1023)}},
    parameter logic [NUM_REGIONS*VW-1:0]     MIN_Y_TAB   = {NUM_REGIONS{VW'(0)}},
    parameter logic [NUM_REGIONS*VW-1:0]     MAX_Y_TAB   = {NUM_REGIONS{VW'(767)}},
    parameter bit                            RECENTER    = 1'b1,
    parameter int                            GAP         = 1
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic [NUM_REGIONS-1:0] mode_btn,
    mouse_region_sequencer_if.master mc
);
    localparam int AW = $clog2(NUM_REGIONS);

    typedef enum logic [3:0] {
        BOOT, IDLE, S_MINX, S_MAXX, S_MINY, S_MAXY, S_X, S_Y, WAIT
    } state_t;

    logic [NUM_REGIONS-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_REGIONS-1:0] edge_vec;
    logic [AW-1:0]          edge_idx;

    state_t        state_q, state_d, nxt_q, nxt_d, tgt;
    logic          step;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] cur_q, cur_d, act_q, act_d, pend_q, pend_d;
    logic          pendv_q, pendv_d;

    logic [5:0]    strb_q, strb_d;
    logic [VW-1:0] value_q, value_d;
    logic          busy_q;
    logic [AW-1:0] mode_q;

    logic [VW-1:0] minx, maxx, miny, maxy, cx, cy;
    logic [VW:0]   sumx, sumy;

    assign edge_vec = sync2_q & ~sync3_q;

    always_comb begin
        edge_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (edge_vec[i]) edge_idx = AW'(i);
        end
    end

    assign minx = MIN_X_TAB[int'(cur_q)*VW +: VW];
    assign maxx = MAX_X_TAB[int'(cur_q)*VW +: VW];
    assign miny = MIN_Y_TAB[int'(cur_q)*VW +: VW];
    assign maxy = MAX_Y_TAB[int'(cur_q)*VW +: VW];
    // Sum one bit wider so regions near full scale still centre correctly.
    assign sumx = {1'b0, minx} + {1'b0, maxx};
    assign sumy = {1'b0, miny} + {1'b0, maxy};
    assign cx   = sumx[VW:1];
    assign cy   = sumy[VW:1];

    function automatic state_t succ(input state_t s);
        case (s)
            S_MINX:  return S_MAXX;
            S_MAXX:  return S_MINY;
            S_MINY:  return S_MAXY;
            S_MAXY:  return RECENTER ? S_X : IDLE;
            S_X:     return S_Y;
            default: return IDLE;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pendv_d = pendv_q;
        step    = 1'b0;
        tgt     = IDLE;

        if (state_q != IDLE && state_q != BOOT && |edge_vec) begin
            pend_d  = edge_idx;
            pendv_d = 1'b1;
        end

        case (state_q)
            BOOT: begin
                cur_d   = '0;
                state_d = S_MINX;
            end
            IDLE: begin
                if (|edge_vec && edge_idx != act_q) begin
                    cur_d   = edge_idx;
                    state_d = S_MINX;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    step = 1'b1;
                    tgt  = nxt_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (GAP == 0) begin
                    step = 1'b1;
                    tgt  = succ(state_q);
                end else begin
                    state_d = WAIT;
                    nxt_d   = succ(state_q);
                    cnt_d   = 4'(GAP - 1);
                end
            end
        endcase

        // IDLE as the step target marks the end of the current sequence.
        if (step) begin
            if (tgt == IDLE) begin
                act_d = cur_q;
                if (pendv_d) begin
                    cur_d   = pend_d;
                    pendv_d = 1'b0;
                    state_d = S_MINX;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                state_d = tgt;
            end
        end
    end

    always_comb begin
        strb_d  = '0;
        value_d = value_q;
        case (state_q)
            S_MINX: begin strb_d[0] = 1'b1; value_d = minx; end
            S_MAXX: begin strb_d[1] = 1'b1; value_d = maxx; end
            S_MINY: begin strb_d[2] = 1'b1; value_d = miny; end
            S_MAXY: begin strb_d[3] = 1'b1; value_d = maxy; end
            S_X:    begin strb_d[4] = 1'b1; value_d = cx;   end
            S_Y:    begin strb_d[5] = 1'b1; value_d = cy;   end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            state_q <= BOOT;
            nxt_q   <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            act_q   <= '0;
            pend_q  <= '0;
            pendv_q <= 1'b0;
            strb_q  <= '0;
            value_q <= '0;
            busy_q  <= 1'b0;
            mode_q  <= '0;
        end else begin
            sync1_q <= mode_btn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            state_q <= state_d;
            nxt_q   <= nxt_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pendv_q <= pendv_d;
            strb_q  <= strb_d;
            value_q <= value_d;
            busy_q  <= (state_q != IDLE) && (state_q != BOOT);
            mode_q  <= act_q;
        end
    end

    assign mc.setmin_x    = strb_q[0];
    assign mc.setmax_x    = strb_q[1];
    assign mc.setmin_y    = strb_q[2];
    assign mc.setmax_y    = strb_q[3];
    assign mc.setx        = strb_q[4];
    assign mc.sety        = strb_q[5];
    assign mc.value       = value_q;
    assign mc.busy        = busy_q;
    assign mc.active_mode = mode_q;
endmodule
